// File: rtl/tcm_port_arb.sv
// Two-requester arbiter for RAM port 1 of the TCM: the CPU normally wins contention,
// and the external (AXI) side is granted once it has lost STARVE_MAX contended cycles in a row.
module tcm_port_arb #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_rd_i,
    input  logic [3:0]  cpu_wr_i,
    input  logic        cpu_maint_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_wr_i,
    input  logic [10:0] cpu_tag_i,
    output logic        cpu_accept_o,
    output logic        cpu_ack_o,
    output logic [10:0] cpu_tag_o,
    output logic [31:0] cpu_data_rd_o,
    input  logic        ext_rd_i,
    input  logic [3:0]  ext_wr_i,
    input  logic [31:0] ext_addr_i,
    input  logic [31:0] ext_data_wr_i,
    output logic        ext_accept_o,
    output logic        ext_ack_o,
    output logic [31:0] ext_data_rd_o,
    output logic [12:0] ram_addr_o,
    output logic [63:0] ram_data_o,
    output logic [7:0]  ram_wr_o,
    input  logic [63:0] ram_data_i
);
    typedef struct packed {
        logic [3:0]  wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    logic        cpu_req, ext_req, ext_wins;
    logic        cpu_gnt, ext_gnt;
    req_t        gnt_req;
    logic [3:0]  strb;
    logic [3:0]  starve_q, starve_d;
    logic        cpu_ack_q, ext_ack_q, lane_q;
    logic [10:0] tag_q;
    logic        unused_addr_bits;

    assign cpu_req  = cpu_rd_i | (|cpu_wr_i) | cpu_maint_i;
    assign ext_req  = ext_rd_i | (|ext_wr_i);
    assign ext_wins = (starve_q == 4'(STARVE_MAX));
    assign ext_gnt  = ext_req & (~cpu_req | ext_wins);
    assign cpu_gnt  = cpu_req & ~(ext_req & ext_wins);

    // Reset forces both accepts high so neither requester stalls against a dead port.
    assign cpu_accept_o = rst_i | ~(ext_req & ext_wins);
    assign ext_accept_o = rst_i | ~(cpu_req & ~ext_wins);

    always_comb begin
        gnt_req = '{wr: cpu_wr_i, addr: cpu_addr_i, data: cpu_data_wr_i};
        if (ext_gnt)
            gnt_req = '{wr: ext_wr_i, addr: ext_addr_i, data: ext_data_wr_i};
        strb = (rst_i || !(cpu_gnt || ext_gnt)) ? 4'h0 : gnt_req.wr;
    end

    assign ram_addr_o = gnt_req.addr[15:3];
    assign ram_wr_o   = gnt_req.addr[2] ? {strb, 4'h0} : {4'h0, strb};
    assign ram_data_o = gnt_req.addr[2] ? {gnt_req.data, 32'h0} : {32'h0, gnt_req.data};

    always_comb begin
        starve_d = starve_q;
        if (ext_gnt)
            starve_d = 4'h0;
        else if (cpu_req && ext_req && starve_q < 4'(STARVE_MAX))
            starve_d = starve_q + 4'h1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q  <= 4'h0;
            cpu_ack_q <= 1'b0;
            ext_ack_q <= 1'b0;
            lane_q    <= 1'b0;
            tag_q     <= 11'h0;
        end else begin
            starve_q  <= starve_d;
            cpu_ack_q <= cpu_gnt;
            ext_ack_q <= ext_gnt;
            if (cpu_gnt || ext_gnt)
                lane_q <= gnt_req.addr[2];
            if (cpu_gnt)
                tag_q <= cpu_tag_i;
        end
    end

    assign cpu_ack_o     = cpu_ack_q;
    assign ext_ack_o     = ext_ack_q;
    assign cpu_tag_o     = tag_q;
    assign cpu_data_rd_o = lane_q ? ram_data_i[63:32] : ram_data_i[31:0];
    assign ext_data_rd_o = lane_q ? ram_data_i[63:32] : ram_data_i[31:0];

    assign unused_addr_bits = ^{cpu_addr_i[31:16], cpu_addr_i[1:0],
                                ext_addr_i[31:16], ext_addr_i[1:0]};
endmodule

// File: tb/tb_tcm_port_arb.sv
// Directed bench for tcm_port_arb: byte-level shadow memory plus a starvation-run model
// checked every cycle, with literal expectations for the hand-worked scenarios.
module tb_tcm_port_arb;
    localparam int SM = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cpu_rd_i = 0, cpu_maint_i = 0, ext_rd_i = 0;
    logic [3:0]  cpu_wr_i = 0, ext_wr_i = 0;
    logic [31:0] cpu_addr_i = 0, cpu_data_wr_i = 0, ext_addr_i = 0, ext_data_wr_i = 0;
    logic [10:0] cpu_tag_i = 0;
    logic        cpu_accept_o, cpu_ack_o, ext_accept_o, ext_ack_o;
    logic [10:0] cpu_tag_o;
    logic [31:0] cpu_data_rd_o, ext_data_rd_o;
    logic [12:0] ram_addr_o;
    logic [63:0] ram_data_o, ram_data_i;
    logic [7:0]  ram_wr_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    tcm_port_arb #(.STARVE_MAX(SM)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i), .cpu_maint_i(cpu_maint_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_wr_i(cpu_data_wr_i), .cpu_tag_i(cpu_tag_i),
        .cpu_accept_o(cpu_accept_o), .cpu_ack_o(cpu_ack_o), .cpu_tag_o(cpu_tag_o),
        .cpu_data_rd_o(cpu_data_rd_o),
        .ext_rd_i(ext_rd_i), .ext_wr_i(ext_wr_i), .ext_addr_i(ext_addr_i),
        .ext_data_wr_i(ext_data_wr_i), .ext_accept_o(ext_accept_o), .ext_ack_o(ext_ack_o),
        .ext_data_rd_o(ext_data_rd_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_wr_o(ram_wr_o),
        .ram_data_i(ram_data_i)
    );

    // RAM attached to port 1: one-cycle read latency, byte-enabled write.
    logic [63:0] ram [0:8191];
    always @(posedge clk_i) begin
        ram_data_i <= ram[ram_addr_o];
        for (int k = 0; k < 8; k++)
            if (ram_wr_o[k]) ram[ram_addr_o][8*k +: 8] <= ram_data_o[8*k +: 8];
    end

    // Reference model: flat byte memory and a count of consecutive ext losses.
    logic [7:0]  sh [0:65535];
    int          m_loss = 0;
    logic        e_cack = 0, e_eack = 0;
    logic [10:0] e_tag = 0;
    logic [31:0] e_data = 0;
    logic        m_cr, m_er, m_gc, m_ge;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_wr;
    logic [15:0] m_base;

    always_comb begin
        m_cr   = cpu_rd_i || (cpu_wr_i != 0) || cpu_maint_i;
        m_er   = ext_rd_i || (ext_wr_i != 0);
        m_ge   = !rst_i && m_er && (!m_cr || m_loss == SM);
        m_gc   = !rst_i && m_cr && !m_ge;
        m_addr = m_ge ? ext_addr_i : cpu_addr_i;
        m_data = m_ge ? ext_data_wr_i : cpu_data_wr_i;
        m_wr   = m_ge ? ext_wr_i : (m_gc ? cpu_wr_i : 4'h0);
        m_base = {m_addr[15:2], 2'b00};
    end

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_loss <= 0;
            e_cack <= 0;
            e_eack <= 0;
        end else begin
            e_cack <= m_gc;
            e_eack <= m_ge;
            if (m_gc) e_tag <= cpu_tag_i;
            if (m_gc || m_ge) begin
                e_data <= {sh[m_base+3], sh[m_base+2], sh[m_base+1], sh[m_base]};
                for (int k = 0; k < 4; k++)
                    if (m_wr[k]) sh[m_base + 16'(k)] <= m_data[8*k +: 8];
            end
            if (m_ge) m_loss <= 0;
            else if (m_cr && m_er) m_loss <= m_loss + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk_i) begin
        logic [7:0] ew;
        ew = m_addr[2] ? {m_wr, 4'h0} : {4'h0, m_wr};
        chk("cpu_accept", 64'(cpu_accept_o), 64'(rst_i || !(m_er && m_loss == SM)));
        chk("ext_accept", 64'(ext_accept_o), 64'(rst_i || !(m_cr && m_loss != SM)));
        chk("ram_wr", 64'(ram_wr_o), 64'(ew));
        if (m_gc || m_ge) begin
            chk("ram_addr", 64'(ram_addr_o), 64'(m_addr[15:3]));
            chk("ram_data", ram_data_o, m_addr[2] ? {m_data, 32'h0} : {32'h0, m_data});
        end
        chk("cpu_ack", 64'(cpu_ack_o), 64'(e_cack));
        chk("ext_ack", 64'(ext_ack_o), 64'(e_eack));
        chk("ack_overlap", 64'(cpu_ack_o & ext_ack_o), 64'h0);
        if (e_cack) begin
            chk("cpu_tag", 64'(cpu_tag_o), 64'(e_tag));
            chk("cpu_data", 64'(cpu_data_rd_o), 64'(e_data));
        end
        if (e_eack) chk("ext_data", 64'(ext_data_rd_o), 64'(e_data));
    end

    function automatic logic [63:0] pat(int i);
        if (i == 32) return 64'hAAAA_BBBB_CCCC_DDDD;
        return {32'(i) * 32'h9E37_79B9, ~(32'(i) * 32'h85EB_CA6B)};
    endfunction

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        cpu_rd_i = 0; cpu_wr_i = 0; cpu_maint_i = 0;
        ext_rd_i = 0; ext_wr_i = 0;
    endtask

    initial begin
        logic [63:0] w;
        logic [9:0]  seq;
        for (int i = 0; i < 8192; i++) begin
            w = pat(i);
            ram[i] = w;
            for (int k = 0; k < 8; k++) sh[i*8 + k] = w[8*k +: 8];
        end

        nxt(); nxt();
        @(negedge clk_i);
        chk("rst_cpu_ack", 64'(cpu_ack_o), 64'h0);
        chk("rst_cpu_tag", 64'(cpu_tag_o), 64'h0);
        chk("rst_accepts", 64'({cpu_accept_o, ext_accept_o}), 64'h3);
        nxt();
        rst_i = 0;

        // CPU-only read of word 0x20, upper half
        cpu_rd_i = 1; cpu_addr_i = 32'h0000_0104; cpu_tag_i = 11'h5A3;
        @(negedge clk_i);
        chk("t15_accept", 64'(cpu_accept_o), 64'h1);
        chk("t15_addr", 64'(ram_addr_o), 64'h020);
        nxt(); idle();
        @(negedge clk_i);
        chk("t15_ack", 64'(cpu_ack_o), 64'h1);
        chk("t15_data", 64'(cpu_data_rd_o), 64'hAAAA_BBBB);
        chk("t15_tag", 64'(cpu_tag_o), 64'h5A3);

        // Ext full-word write, lower lane
        nxt();
        ext_wr_i = 4'hF; ext_addr_i = 32'h0000_0008; ext_data_wr_i = 32'h1234_5678;
        @(negedge clk_i);
        chk("t16_wr", 64'(ram_wr_o), 64'h0F);
        chk("t16_data", 64'(ram_data_o[31:0]), 64'h1234_5678);
        chk("t16_addr", 64'(ram_addr_o), 64'h001);
        nxt(); idle();
        @(negedge clk_i);
        chk("t16_ack", 64'(ext_ack_o), 64'h1);

        // CPU partial write upper lane, then ext reads it back
        nxt();
        cpu_wr_i = 4'b0110; cpu_addr_i = 32'h0000_010C; cpu_data_wr_i = 32'hDEAD_BEEF; cpu_tag_i = 11'h001;
        @(negedge clk_i);
        chk("pw_wr", 64'(ram_wr_o), 64'h60);
        nxt(); idle();
        ext_rd_i = 1; ext_addr_i = 32'h0000_010C;
        nxt(); idle();
        nxt();
        ext_rd_i = 1; ext_addr_i = 32'h0000_0008;
        nxt(); idle();
        @(negedge clk_i);
        chk("t16_readback", 64'(ext_data_rd_o), 64'h1234_5678);

        // Maintenance-only request
        nxt();
        cpu_maint_i = 1; cpu_tag_i = 11'h7FF; cpu_addr_i = 32'h0000_0040;
        @(negedge clk_i);
        chk("t18_wr", 64'(ram_wr_o), 64'h0);
        nxt(); idle();
        @(negedge clk_i);
        chk("t18_ack", 64'(cpu_ack_o), 64'h1);
        chk("t18_tag", 64'(cpu_tag_o), 64'h7FF);

        // Continuous contention: CPU x4, ext x1, repeating
        nxt();
        cpu_rd_i = 1; cpu_addr_i = 32'h0000_0200; cpu_tag_i = 11'h0C3;
        ext_rd_i = 1; ext_addr_i = 32'h0000_0304;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            seq[i] = cpu_accept_o;
            nxt();
        end
        chk("t17_pattern", 64'(seq), 64'(10'b0111101111));

        // Build starvation to the limit, reset mid-cycle, CPU must win next contention
        for (int i = 0; i < SM; i++) nxt();
        rst_i = 1;
        nxt();
        rst_i = 0;
        @(negedge clk_i);
        chk("rst_starve_cpu", 64'({cpu_accept_o, ext_accept_o}), 64'h2);
        nxt(); idle();

        // Reset in the cycle after an ext accept
        nxt();
        ext_rd_i = 1; ext_addr_i = 32'h0000_0010;
        nxt(); idle();
        rst_i = 1;
        @(negedge clk_i);
        chk("t19_ext_ack", 64'(ext_ack_o), 64'h0);
        chk("t19_rst_wr", 64'(ram_wr_o), 64'h0);
        nxt();
        rst_i = 0;
        cpu_rd_i = 1; cpu_addr_i = 32'h0000_0020; ext_rd_i = 1; ext_addr_i = 32'h0000_0028;
        @(negedge clk_i);
        chk("t19_first_cpu", 64'({cpu_accept_o, ext_accept_o}), 64'h2);
        nxt(); cpu_rd_i = 0;
        nxt(); idle();
        nxt(); nxt();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
